// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared APB requester types: FSM state encoding, address alignment, write command record
package apb_pkg;

    typedef enum logic [1:0] {
        APB_IDLE   = 2'd0,
        APB_SETUP  = 2'd1,
        APB_ACCESS = 2'd2
    } apb_state_e;

    // APB transfers are word sized; address bits below this are forced to zero.
    localparam int APB_ADDR_LSB = 2;

    localparam int APB_CMD_ADDR_W = 32;
    localparam int APB_CMD_DATA_W = 32;

    typedef struct packed {
        logic [APB_CMD_ADDR_W-1:0] addr;
        logic [APB_CMD_DATA_W-1:0] wdata;
    } apb_wr_cmd_t;

endpackage

// File: rtl/apb_timeout_cnt.sv
// rtl/apb_timeout_cnt.sv - wait-state counter that flags an ACCESS phase stalled for TIMEOUT cycles
//
// Ports:
//   PCLK, PRESETn : clock, asynchronous active-low reset
//   clr           : hold the count at zero (asserted whenever not in ACCESS)
//   en            : count this cycle (ACCESS with PREADY low)
//   expired       : this stalled cycle is the TIMEOUT-th one; combinational
module apb_timeout_cnt #(
    parameter int TIMEOUT = 16
) (
    input  logic PCLK,
    input  logic PRESETn,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    // The count reaches TIMEOUT at the end of the stalled cycle where it holds TIMEOUT-1.
    localparam logic [CW-1:0] LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    logic [CW-1:0] cnt;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && (TIMEOUT > 0)) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign expired = (TIMEOUT > 0) && en && (cnt == LAST);

endmodule

// File: rtl/apb_write_master.sv
// rtl/apb_write_master.sv - APB3 write requester: one valid/ready command in, one APB write and one response out
//
// Ports:
//   PCLK, PRESETn           : APB clock, asynchronous active-low reset
//   cmd_valid/cmd_ready     : command handshake; cmd_addr (byte address), cmd_wdata
//   rsp_valid               : one-cycle completion pulse
//   rsp_err, rsp_timeout    : completion status, held until the next completion
//   busy                    : a transfer is in SETUP or ACCESS
//   PSEL..PWDATA            : registered APB requester outputs
//   PREADY, PSLVERR         : completer handshake, only looked at in ACCESS
module apb_write_master
    import apb_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic              rsp_err,
    output logic              rsp_timeout,
    output logic              busy,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [ADDR_W-1:0] PADDR,
    output logic [DATA_W-1:0] PWDATA,
    input  logic              PREADY,
    input  logic              PSLVERR
);

    localparam logic [ADDR_W-1:0] ADDR_MASK = ~ADDR_W'((1 << APB_ADDR_LSB) - 1);

    apb_state_e state;
    logic       tmo_expired;

    // Ready in the completion cycle too, so a waiting command goes straight to SETUP.
    assign cmd_ready = (state == APB_IDLE) || ((state == APB_ACCESS) && PREADY);
    assign busy      = (state != APB_IDLE);

    apb_timeout_cnt #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout_cnt (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .clr     (state != APB_ACCESS),
        .en      ((state == APB_ACCESS) && !PREADY),
        .expired (tmo_expired)
    );

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state       <= APB_IDLE;
            PSEL        <= 1'b0;
            PENABLE     <= 1'b0;
            PWRITE      <= 1'b0;
            PADDR       <= '0;
            PWDATA      <= '0;
            rsp_valid   <= 1'b0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                APB_IDLE: begin
                    if (cmd_valid) begin
                        PADDR   <= cmd_addr & ADDR_MASK;
                        PWDATA  <= cmd_wdata;
                        PSEL    <= 1'b1;
                        PENABLE <= 1'b0;
                        PWRITE  <= 1'b1;
                        state   <= APB_SETUP;
                    end
                end
                APB_SETUP: begin
                    PENABLE <= 1'b1;
                    state   <= APB_ACCESS;
                end
                APB_ACCESS: begin
                    // PREADY is tested first so a completion on the last allowed cycle wins.
                    if (PREADY) begin
                        rsp_valid   <= 1'b1;
                        rsp_err     <= PSLVERR;
                        rsp_timeout <= 1'b0;
                        if (cmd_valid) begin
                            PADDR   <= cmd_addr & ADDR_MASK;
                            PWDATA  <= cmd_wdata;
                            PENABLE <= 1'b0;
                            state   <= APB_SETUP;
                        end else begin
                            PSEL    <= 1'b0;
                            PENABLE <= 1'b0;
                            PWRITE  <= 1'b0;
                            state   <= APB_IDLE;
                        end
                    end else if (tmo_expired) begin
                        rsp_valid   <= 1'b1;
                        rsp_err     <= 1'b1;
                        rsp_timeout <= 1'b1;
                        PSEL        <= 1'b0;
                        PENABLE     <= 1'b0;
                        PWRITE      <= 1'b0;
                        state       <= APB_IDLE;
                    end
                end
                default: begin
                    PSEL    <= 1'b0;
                    PENABLE <= 1'b0;
                    PWRITE  <= 1'b0;
                    state   <= APB_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/apb_write_master.md
Name: apb_write_master

Overview:
APB3 requester that turns a valid/ready write-command stream into APB write transfers, one at a time. Sits between an internal bus/CSR sequencer and any APB write completer on the same PCLK domain, such as the 256x32 register/memory slave. Returns one response per command, carrying error status from PSLVERR or from an internal wait-state timeout.

Parameters:
ADDR_W, 32, width of cmd_addr and PADDR
DATA_W, 32, width of cmd_wdata and PWDATA
TIMEOUT, 16, max ACCESS cycles with PREADY low before abort; 0 disables the timeout

Ports:
PCLK  in  1  APB clock
PRESETn  in  1  async active-low reset
cmd_valid  in  1  write command valid
cmd_ready  out  1  command accepted when valid&&ready
cmd_addr  in  ADDR_W  byte address
cmd_wdata  in  DATA_W  write data
rsp_valid  out  1  one-cycle completion pulse
rsp_err  out  1  completion error (PSLVERR or timeout), valid with rsp_valid
rsp_timeout  out  1  completion was a timeout abort, valid with rsp_valid
busy  out  1  state != IDLE
PSEL  out  1  APB select
PENABLE  out  1  APB enable
PWRITE  out  1  APB direction, always write
PADDR  out  ADDR_W  APB address, word aligned
PWDATA  out  DATA_W  APB write data
PREADY  in  1  completer ready
PSLVERR  in  1  completer error

Behaviour:
- Clock is PCLK. Reset is PRESETn, asynchronous, active-low.
- Reset values: PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, rsp_valid=0, rsp_err=0, rsp_timeout=0, state=IDLE, timeout counter=0.
- FSM states are IDLE, SETUP and ACCESS. All APB outputs and rsp_* are registered.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid: latch PADDR={cmd_addr[ADDR_W-1:2],2'b00} (bits [1:0] forced to 0) and PWDATA=cmd_wdata. Go to SETUP.
- SETUP (exactly 1 cycle): PSEL=1, PENABLE=0, PWRITE=1. Go to ACCESS.
- ACCESS:
  - PSEL=1, PENABLE=1. PADDR and PWDATA are held stable.
  - Wait counter clears on ACCESS entry and increments each cycle PREADY=0.
- Completion (PREADY=1 in ACCESS):
  - Next cycle: rsp_valid=1 for exactly one cycle, rsp_err=PSLVERR sampled in the completion cycle, rsp_timeout=0.
  - cmd_ready=1 in the completion cycle (combinational on PREADY). If cmd_valid is also high, latch the new command and go directly to SETUP, giving back-to-back transfers with no IDLE cycle. Otherwise go to IDLE with PSEL=0, PENABLE=0, PWRITE=0.
- Timeout (TIMEOUT>0, counter reaches TIMEOUT with PREADY still 0):
  - Drop PSEL/PENABLE next cycle and go to IDLE.
  - rsp_valid=1, rsp_err=1, rsp_timeout=1.
  - A PREADY arriving in the same cycle the count reaches TIMEOUT wins: normal completion, no timeout.
- Latency, zero-wait completer: command accepted at edge N, SETUP at N+1, ACCESS at N+2, rsp_valid at N+3.
- cmd_ready=0 in SETUP and in ACCESS while PREADY=0. Only one outstanding transfer at a time.
- Fields outside the active transfer:
  - PADDR/PWDATA keep their last value in IDLE; do not care to the completer.
  - rsp_err and rsp_timeout keep their last value when rsp_valid=0.
- Reset mid-transfer: all outputs return to reset values immediately. The transfer is dropped and no response is issued.
- PREADY and PSLVERR are ignored outside ACCESS.

Decomposition:
- Package apb_pkg holds:
  - enum apb_state_e {APB_IDLE, APB_SETUP, APB_ACCESS}
  - localparam APB_ADDR_LSB=2
  - struct apb_wr_cmd_t {addr, wdata}, shared with the future read master.
- One natural sub-module, apb_timeout_cnt: clear/enable inputs, expired output, TIMEOUT parameter, $clog2(TIMEOUT+1)-bit counter.

Test Plan:
- Single write: cmd_addr=0x10, cmd_wdata=0xDEADBEEF, PREADY tied 1. Required: PSEL rises at N+1, PENABLE at N+2, PADDR=0x10, PWDATA=0xDEADBEEF, rsp_valid at N+3 with rsp_err=0.
- Wait states: PREADY low for 3 ACCESS cycles. Required: PENABLE high 4 cycles, PADDR/PWDATA stable throughout, exactly one rsp_valid.
- Back-to-back: 3 commands held valid (0x0/0x11111111, 0x4/0x22222222, 0x8/0x33333333), zero-wait. Required: PSEL stays high for all 6 cycles, SETUP/ACCESS alternate, 3 rsp_valid pulses.
- Slave error and alignment: PSLVERR=1 with PREADY=1 on cmd_addr=0x7. Required: PADDR=0x4, rsp_err=1, rsp_timeout=0.
- Timeout: TIMEOUT=16, PREADY held 0. Required: PSEL/PENABLE drop after 16 ACCESS cycles, rsp_valid=1 with rsp_err=1 and rsp_timeout=1, cmd_ready=1 the following cycle.
- Reset mid-ACCESS: assert PRESETn=0 during the 2nd wait cycle. Required: PSEL/PENABLE/PWRITE=0 asynchronously, no rsp_valid, a new command after release completes normally.
